// File: rtl/rsa_stream_unpacker.sv
// ============================================================================
// Module      : rsa_stream_unpacker
// Description : Serializes one packed RSA block into MSB-first symbols
//               (14-bit ciphertext or 7-bit plaintext) over valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rsa_stream_unpacker #(
    parameter int STREAM_W = 1023,
    parameter int PT_W     = 7,
    parameter int CT_W     = 14,
    parameter int MAX_PT   = 146,
    parameter int MAX_CT   = 73
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [STREAM_W-1:0] in_stream,
    input  logic                in_mode,
    input  logic [7:0]          in_count,
    output logic                sym_valid,
    input  logic                sym_ready,
    output logic [CT_W-1:0]     sym_data,
    output logic [7:0]          sym_index,
    output logic                sym_last,
    output logic                done,
    output logic                count_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EMIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [STREAM_W-1:0] shreg_q, shreg_d;
    logic                mode_q, mode_d;
    logic [7:0]          count_q, count_d;
    logic [7:0]          idx_q, idx_d;
    logic                err_q, err_d;

    logic [CT_W-1:0]     w_head;
    logic [CT_W-1:0]     w_next;
    logic                w_head_zero;
    logic                w_last;
    logic [7:0]          w_max;
    logic                w_emit;

    // Plaintext symbols are zero-extended so both modes share one datapath width.
    always_comb begin
        if (mode_q) begin
            w_head = {{(CT_W-PT_W){1'b0}}, shreg_q[STREAM_W-1 -: PT_W]};
            w_next = {{(CT_W-PT_W){1'b0}}, shreg_q[STREAM_W-1-PT_W -: PT_W]};
        end else begin
            w_head = shreg_q[STREAM_W-1 -: CT_W];
            w_next = shreg_q[STREAM_W-1-CT_W -: CT_W];
        end
    end

    assign w_head_zero = (w_head == '0);
    assign w_last      = (idx_q == (count_q - 8'd1)) || (w_next == '0);
    assign w_max       = in_mode ? 8'(MAX_PT) : 8'(MAX_CT);
    assign w_emit      = (state_q == S_EMIT) && !w_head_zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            shreg_q <= '0;
            mode_q  <= 1'b0;
            count_q <= 8'd0;
            idx_q   <= 8'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            mode_q  <= mode_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        mode_d  = mode_q;
        count_d = count_q;
        idx_d   = idx_q;
        err_d   = err_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    shreg_d = in_stream;
                    mode_d  = in_mode;
                    idx_d   = 8'd0;
                    if (in_count > w_max) begin
                        count_d = w_max;
                        err_d   = 1'b1;
                    end else begin
                        count_d = in_count;
                        err_d   = 1'b0;
                    end
                    state_d = (in_count == 8'd0) ? S_DONE : S_EMIT;
                end
            end
            S_EMIT: begin
                // A zero head is the terminator: it ends the block without being emitted.
                if (w_head_zero) begin
                    state_d = S_DONE;
                end else if (sym_ready) begin
                    if (w_last) begin
                        state_d = S_DONE;
                    end else begin
                        shreg_d = mode_q ? (shreg_q << PT_W) : (shreg_q << CT_W);
                        idx_d   = idx_q + 8'd1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == S_IDLE);
    assign sym_valid = w_emit;
    assign sym_data  = w_emit ? w_head : '0;
    assign sym_index = w_emit ? idx_q : 8'd0;
    assign sym_last  = w_emit && w_last;
    assign done      = (state_q == S_DONE);
    assign count_err = err_q;

endmodule

`default_nettype wire

// File: tb/tb_rsa_stream_unpacker.sv
// ============================================================================
// Module      : tb_rsa_stream_unpacker
// Description : Table-driven self-checking bench for rsa_stream_unpacker.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rsa_stream_unpacker;

    localparam int STREAM_W = 1023;

    logic                clk;
    logic                rst_n;
    logic                in_valid;
    logic                in_ready;
    logic [STREAM_W-1:0] in_stream;
    logic                in_mode;
    logic [7:0]          in_count;
    logic                sym_valid;
    logic                sym_ready;
    logic [13:0]         sym_data;
    logic [7:0]          sym_index;
    logic                sym_last;
    logic                done;
    logic                count_err;

    int checks = 0;
    int errors = 0;

    logic [13:0] sym_buf [160];

    rsa_stream_unpacker dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_stream (in_stream),
        .in_mode   (in_mode),
        .in_count  (in_count),
        .sym_valid (sym_valid),
        .sym_ready (sym_ready),
        .sym_data  (sym_data),
        .sym_index (sym_index),
        .sym_last  (sym_last),
        .done      (done),
        .count_err (count_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string          name;
        logic           mode;
        logic [7:0]     cnt;
        int             nsym;
        logic [3:0][13:0] sym;
        bit             stall;
        int             exp_n;
        int             done_cyc;
        logic           err;
    } vec_t;

    vec_t vecs [8];

    function automatic vec_t mk(input string n, input logic m, input logic [7:0] c, input int ns,
                                input logic [13:0] s0, input logic [13:0] s1,
                                input logic [13:0] s2, input logic [13:0] s3,
                                input bit st, input int en, input int dc, input logic e);
        vec_t v;
        v.name = n; v.mode = m; v.cnt = c; v.nsym = ns;
        v.sym[0] = s0; v.sym[1] = s1; v.sym[2] = s2; v.sym[3] = s3;
        v.stall = st; v.exp_n = en; v.done_cyc = dc; v.err = e;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [STREAM_W-1:0] pack(input logic m, input int n);
        logic [STREAM_W-1:0] s;
        s = '0;
        for (int i = 0; i < n; i++) begin
            if (m) s[STREAM_W-1-7*i -: 7] = sym_buf[i][6:0];
            else   s[STREAM_W-1-14*i -: 14] = sym_buf[i];
        end
        return s;
    endfunction

    // Loads one block, then walks the output until done, checking every presented symbol.
    task automatic run_block(input string nm, input logic m, input logic [7:0] c,
                             input logic [STREAM_W-1:0] s, input int en, input bit st,
                             input int dc, input logic e);
        int k;
        int done_at;
        @(negedge clk);
        chk({nm, " load_ready"}, 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        in_mode   = m;
        in_count  = c;
        in_stream = s;
        @(negedge clk);
        in_valid = 1'b0;
        k = 0;
        done_at = -1;
        for (int cyc = 0; cyc < 400 && done_at < 0; cyc++) begin
            sym_ready = st ? (cyc % 2 == 0) : 1'b1;
            if (done) begin
                done_at = cyc;
                chk({nm, " valid_at_done"}, 32'(sym_valid), 32'd0);
            end else if (sym_valid) begin
                if (k >= en) begin
                    chk({nm, " extra_symbol_idx"}, 32'(sym_index), 32'(en - 1));
                end else begin
                    chk($sformatf("%s data[%0d]", nm, k), 32'(sym_data), 32'(sym_buf[k]));
                    chk($sformatf("%s index[%0d]", nm, k), 32'(sym_index), 32'(k));
                    chk($sformatf("%s last[%0d]", nm, k), 32'(sym_last), 32'(k == en - 1));
                end
                if (sym_ready) k++;
            end
            if (done_at < 0) @(negedge clk);
        end
        chk({nm, " done_cycle"}, 32'(done_at), 32'(dc));
        chk({nm, " handshakes"}, 32'(k), 32'(en));
        chk({nm, " count_err"}, 32'(count_err), 32'(e));
        @(negedge clk);
        chk({nm, " done_one_cycle"}, 32'(done), 32'd0);
        chk({nm, " ready_after_done"}, 32'(in_ready), 32'd1);
        sym_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [STREAM_W-1:0] s;

        vecs[0] = mk("pt2",       1'b1, 8'd2, 2, 14'h48, 14'h69, 14'h0, 14'h0, 1'b0, 2, 2, 1'b0);
        vecs[1] = mk("ct3_stall", 1'b0, 8'd3, 3, 14'd1234, 14'd5, 14'd9999, 14'h0, 1'b1, 3, 5, 1'b0);
        vecs[2] = mk("zero_term", 1'b1, 8'd5, 4, 14'h41, 14'h42, 14'h00, 14'h43, 1'b0, 2, 2, 1'b0);
        vecs[3] = mk("cnt0_pt",   1'b1, 8'd0, 2, 14'h41, 14'h42, 14'h0, 14'h0, 1'b0, 0, 0, 1'b0);
        vecs[4] = mk("cnt0_ct",   1'b0, 8'd0, 2, 14'd77, 14'd88, 14'h0, 14'h0, 1'b0, 0, 0, 1'b0);
        vecs[5] = mk("head_zero", 1'b1, 8'd3, 2, 14'h00, 14'h78, 14'h0, 14'h0, 1'b0, 0, 1, 1'b0);
        vecs[6] = mk("cnt_trunc", 1'b0, 8'd2, 3, 14'd100, 14'd200, 14'd300, 14'h0, 1'b0, 2, 2, 1'b0);
        vecs[7] = mk("pt_count1", 1'b1, 8'd1, 1, 14'h5A, 14'h0, 14'h0, 14'h0, 1'b0, 1, 1, 1'b0);

        rst_n = 1'b0; in_valid = 1'b0; in_stream = '0; in_mode = 1'b0;
        in_count = 8'd0; sym_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("reset in_ready",  32'(in_ready),  32'd1);
        chk("reset sym_valid", 32'(sym_valid), 32'd0);
        chk("reset sym_data",  32'(sym_data),  32'd0);
        chk("reset sym_index", 32'(sym_index), 32'd0);
        chk("reset sym_last",  32'(sym_last),  32'd0);
        chk("reset done",      32'(done),      32'd0);
        chk("reset count_err", 32'(count_err), 32'd0);
        rst_n = 1'b1;

        for (int v = 0; v < 8; v++) begin
            for (int i = 0; i < 4; i++) sym_buf[i] = vecs[v].sym[i];
            s = pack(vecs[v].mode, vecs[v].nsym);
            run_block(vecs[v].name, vecs[v].mode, vecs[v].cnt, s, vecs[v].exp_n,
                      vecs[v].stall, vecs[v].done_cyc, vecs[v].err);
        end

        // Overflow: 200 requested, 73 ciphertext slots available.
        for (int i = 0; i < 73; i++) sym_buf[i] = 14'(i + 1);
        s = pack(1'b0, 73);
        run_block("overflow", 1'b0, 8'd200, s, 73, 1'b0, 73, 1'b1);

        sym_buf[0] = 14'd7;
        s = pack(1'b0, 1);
        run_block("err_clear", 1'b0, 8'd1, s, 1, 1'b0, 1, 1'b0);

        // Reset in the middle of a full plaintext block.
        for (int i = 0; i < 146; i++) sym_buf[i] = 14'(7'h21 + (i % 90));
        s = pack(1'b1, 146);
        @(negedge clk);
        in_valid = 1'b1; in_mode = 1'b1; in_count = 8'd146; in_stream = s;
        @(negedge clk);
        in_valid = 1'b0;
        sym_ready = 1'b1;
        for (int i = 0; i < 10; i++) @(negedge clk);
        chk("midrst pre_valid", 32'(sym_valid), 32'd1);
        chk("midrst pre_index", 32'(sym_index), 32'd10);
        chk("midrst pre_data",  32'(sym_data),  32'(7'h21 + 10));
        #2 rst_n = 1'b0;
        #1;
        chk("midrst in_ready",  32'(in_ready),  32'd1);
        chk("midrst sym_valid", 32'(sym_valid), 32'd0);
        chk("midrst sym_data",  32'(sym_data),  32'd0);
        chk("midrst sym_index", 32'(sym_index), 32'd0);
        chk("midrst sym_last",  32'(sym_last),  32'd0);
        chk("midrst count_err", 32'(count_err), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("midrst no_done", 32'(done), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst idle_no_done", 32'(done), 32'd0);
        sym_ready = 1'b0;

        sym_buf[0] = 14'h48; sym_buf[1] = 14'h69;
        s = pack(1'b1, 2);
        run_block("after_rst", 1'b1, 8'd2, s, 2, 1'b0, 2, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
